wshb_arbiter: RTL

WSHB_ARBITER -- requirements
Module: wshb_arbiter

---
 rtl/wshb_arb_pkg.sv | 13 +
 rtl/wshb_if.sv | 25 ++
 rtl/wshb_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone arbiter.
package wshb_arb_pkg;

  // Default number of acknowledged transfers a grantee keeps before yielding.
  localparam int unsigned QUANTUM_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    GNT_VGA,
    GNT_MIRE
  } arb_state_e;

endpackage

// File: rtl/wshb_if.sv
// 32-bit Wishbone B4 classic/registered-burst bus bundle.
interface wshb_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack
  );

endinterface

// File: rtl/wshb_arbiter.sv
// Round-robin-with-quantum arbiter sharing one SDRAM Wishbone slave between
// the framebuffer reader (requester 0, priority on ties) and the pattern writer.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int unsigned QUANTUM = QUANTUM_DEFAULT
) (
  input logic   clk,
  input logic   rst,
  wshb_if.slave  wshb_ifs_vga,
  wshb_if.slave  wshb_ifs_mire,
  wshb_if.master wshb_ifm
);

  // Keep the counter at least one bit wide so QUANTUM == 1 still elaborates.
  localparam int unsigned CntW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(QUANTUM - 1);

  arb_state_e      state;
  logic [CntW-1:0] cnt;

  // Grant state and per-quantum ack counter; cyc drop takes precedence over quantum expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (wshb_ifs_vga.cyc) begin
            state <= GNT_VGA;
          end else if (wshb_ifs_mire.cyc) begin
            state <= GNT_MIRE;
          end
        end
        GNT_VGA: begin
          if (!wshb_ifs_vga.cyc) begin
            cnt   <= '0;
            state <= wshb_ifs_mire.cyc ? GNT_MIRE : IDLE;
          end else if (wshb_ifm.ack) begin
            if (cnt == CntLast) begin
              cnt <= '0;
              if (wshb_ifs_mire.cyc) begin
                state <= GNT_MIRE;
              end
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
        end
        GNT_MIRE: begin
          if (!wshb_ifs_mire.cyc) begin
            cnt   <= '0;
            state <= wshb_ifs_vga.cyc ? GNT_VGA : IDLE;
          end else if (wshb_ifm.ack) begin
            if (cnt == CntLast) begin
              cnt <= '0;
              if (wshb_ifs_vga.cyc) begin
                state <= GNT_VGA;
              end
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Read data goes to both requesters; only the grantee's ack is meaningful.
  assign wshb_ifs_vga.dat_sm  = wshb_ifm.dat_sm;
  assign wshb_ifs_mire.dat_sm = wshb_ifm.dat_sm;

  // Forward the grantee onto the shared bus and route ack back to it alone.
  always_comb begin
    wshb_ifm.cyc       = 1'b0;
    wshb_ifm.stb       = 1'b0;
    wshb_ifm.we        = 1'b0;
    wshb_ifm.adr       = '0;
    wshb_ifm.dat_ms    = '0;
    wshb_ifm.sel       = '0;
    wshb_ifm.cti       = '0;
    wshb_ifm.bte       = '0;
    wshb_ifs_vga.ack   = 1'b0;
    wshb_ifs_mire.ack  = 1'b0;
    unique case (state)
      GNT_VGA: begin
        wshb_ifm.cyc     = wshb_ifs_vga.cyc;
        wshb_ifm.stb     = wshb_ifs_vga.stb;
        wshb_ifm.we      = wshb_ifs_vga.we;
        wshb_ifm.adr     = wshb_ifs_vga.adr;
        wshb_ifm.dat_ms  = wshb_ifs_vga.dat_ms;
        wshb_ifm.sel     = wshb_ifs_vga.sel;
        wshb_ifm.cti     = wshb_ifs_vga.cti;
        wshb_ifm.bte     = wshb_ifs_vga.bte;
        wshb_ifs_vga.ack = wshb_ifm.ack;
      end
      GNT_MIRE: begin
        wshb_ifm.cyc      = wshb_ifs_mire.cyc;
        wshb_ifm.stb      = wshb_ifs_mire.stb;
        wshb_ifm.we       = wshb_ifs_mire.we;
        wshb_ifm.adr      = wshb_ifs_mire.adr;
        wshb_ifm.dat_ms   = wshb_ifs_mire.dat_ms;
        wshb_ifm.sel      = wshb_ifs_mire.sel;
        wshb_ifm.cti      = wshb_ifs_mire.cti;
        wshb_ifm.bte      = wshb_ifs_mire.bte;
        wshb_ifs_mire.ack = wshb_ifm.ack;
      end
      default: ;
    endcase
  end

endmodule
